// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// -----------------------------------------------------------------------------
// Program-counter register and instruction-fetch sequencer for the multi-cycle
// MIPS core.
//
// The block holds the architectural PC and issues one word fetch per
// instruction to instruction memory. It latches the returned word into the
// instruction register (IR). When control commits, it loads the next PC
// produced by the next-PC logic. `pc` feeds that logic, and `npc_in` is its
// result.
//
// Parameters
//   RESET_PC     PC value loaded on reset.
//
// Ports
//   clk          single clock, rising-edge active
//   rst          synchronous, active-high reset
//   npc_in       next PC from the next-PC logic
//   pc_we        commit strobe; honoured only while an instruction is held
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch byte address (always equals pc)
//   imem_ack     memory response strobe
//   imem_rdata   instruction word, valid with imem_ack
//   pc           current PC
//   instr        instruction register contents
//   instr_valid  IR holds the instruction at pc
//   addr_err     PC was loaded with a non-word-aligned value (sticky to reset)
//   retire_cnt   committed-instruction count, wraps modulo 2^32
//   dbg_state    current FSM state code, for observation only
//
// Memory handshake
//   imem_req is the request-valid and imem_ack is the response-ready/accept.
//   While imem_req=1, imem_addr is held constant until the cycle in which
//   imem_ack=1 is sampled. That edge completes the transfer: imem_rdata is
//   captured and imem_req drops on the following cycle. An ack sampled while
//   imem_req=0 is not part of any transfer and has no effect. The request is
//   never withdrawn before ack except by rst.
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_in,
  input  logic        pc_we,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        addr_err,
  output logic [31:0] retire_cnt,
  output logic [1:0]  dbg_state
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_BOOT  = 2'd0;  // one idle cycle out of reset
  localparam logic [1:0] S_FETCH = 2'd1;  // request outstanding, waiting on ack
  localparam logic [1:0] S_HOLD  = 2'd2;  // IR valid, waiting on commit
  localparam logic [1:0] S_ERR   = 2'd3;  // misaligned PC, parked until reset

  logic [1:0]  state;
  logic [1:0]  state_d;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [31:0] retire_cnt_d;

  // Qualified events. The ack is accepted only while a request is actually
  // outstanding, and a commit is accepted only while an instruction is held.
  // Every other occurrence of these inputs is ignored.
  logic fetch_done;
  logic commit;
  logic npc_misaligned;

  assign fetch_done     = (state == S_FETCH) && imem_ack;
  assign commit         = (state == S_HOLD) && pc_we;
  assign npc_misaligned = (npc_in[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    instr_d      = instr;
    retire_cnt_d = retire_cnt;

    case (state)
      S_BOOT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (fetch_done) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (commit) begin
          pc_d = npc_in;
          // The commit that lands on a misaligned target still retires the
          // instruction that produced it, so it is counted here too.
          retire_cnt_d = retire_cnt + 32'd1;
          state_d      = npc_misaligned ? S_ERR : S_FETCH;
        end
      end

      S_ERR: begin
        // pc keeps the offending value so it can be inspected.
        state_d = S_ERR;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // Every register is written on every non-reset edge from its *_d value. The
  // hold case is expressed in the comb block, not by skipping the assignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      instr      <= 32'd0;
      retire_cnt <= 32'd0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      instr      <= instr_d;
      retire_cnt <= retire_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registered state or pure state decodes, no input-to-output paths
  // ---------------------------------------------------------------------------
  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  // S_ERR can only be left through reset, so decoding it gives the sticky flag.
  assign addr_err    = (state == S_ERR);
  assign dbg_state   = state;

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// -----------------------------------------------------------------------------
// Self-checking bench for pc_fetch. Inputs are driven and outputs are sampled
// on the falling clock edge. Fetched words are pushed to exp_q when the ack is
// driven. They are popped and compared when the DUT reports instr_valid.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc_in = 32'd0;
  logic        pc_we = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;
  logic [31:0] retire_cnt;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .npc_in      (npc_in),
    .pc_we       (pc_we),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .addr_err    (addr_err),
    .retire_cnt  (retire_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic [31:0] npc;
    bit          stray_we;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Reset for the given number of cycles. On return the DUT is in its boot
  // cycle and the reset values are checked.
  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    pc_we    = 1'b0;
    imem_ack = 1'b0;
    repeat (cycles) tick();
    rst     = 1'b0;
    exp_pc  = RESET_PC;
    exp_cnt = 32'd0;
    exp_q.delete();
    check1("rst_req",     imem_req,    1'b0);
    check1("rst_valid",   instr_valid, 1'b0);
    check1("rst_err",     addr_err,    1'b0);
    check ("rst_pc",      pc,          RESET_PC);
    check ("rst_instr",   instr,       32'd0);
    check ("rst_cnt",     retire_cnt,  32'd0);
  endtask

  // Wait (bounded) for a request, stall for the given number of cycles, then
  // return the word. Optionally pulse pc_we during the stall cycles.
  task automatic fetch(input int waits, input logic [31:0] data, input bit stray_we);
    bit          ok;
    logic [31:0] exp_instr;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL fetch_req_timeout: imem_req still %b after 20 cycles", imem_req);
      return;
    end
    check("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      pc_we      = stray_we;
      npc_in     = $urandom;
      tick();
      check1("wait_req_held",    imem_req,    1'b1);
      check ("wait_addr_stable", imem_addr,   exp_pc);
      check1("wait_valid_low",   instr_valid, 1'b0);
      check ("wait_pc",          pc,          exp_pc);
      check ("wait_cnt",         retire_cnt,  exp_cnt);
    end
    pc_we      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back(data);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check1("ack_valid", instr_valid, 1'b1);
    check1("ack_req",   imem_req,    1'b0);
    check ("ack_pc",    pc,          exp_pc);
    if (instr_valid) begin
      exp_instr = exp_q.pop_front();
      check("ack_instr", instr, exp_instr);
    end
  endtask

  // Commit from S_HOLD and check the cycle after.
  task automatic commit(input logic [31:0] npc);
    pc_we  = 1'b1;
    npc_in = npc;
    tick();
    pc_we   = 1'b0;
    npc_in  = $urandom;
    exp_pc  = npc;
    exp_cnt = exp_cnt + 32'd1;
    check ("commit_pc",    pc,          npc);
    check ("commit_cnt",   retire_cnt,  exp_cnt);
    check1("commit_valid", instr_valid, 1'b0);
    if (npc[1:0] == 2'b00) begin
      check1("commit_req",  imem_req,  1'b1);
      check ("commit_addr", imem_addr, npc);
      check1("commit_err",  addr_err,  1'b0);
    end else begin
      check1("commit_req_err", imem_req, 1'b0);
      check1("commit_err_set", addr_err, 1'b1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] held;

    vecs[0] = '{waits: 0, rdata: $urandom, npc: 32'h0000_3008, stray_we: 1'b0};
    vecs[1] = '{waits: 2, rdata: $urandom, npc: 32'h0000_3100, stray_we: 1'b1};
    vecs[2] = '{waits: 1, rdata: $urandom, npc: 32'h0000_0400, stray_we: 1'b1};
    vecs[3] = '{waits: $urandom_range(0, 4), rdata: $urandom, npc: 32'h0000_3FFC, stray_we: 1'b0};
    vecs[4] = '{waits: $urandom_range(0, 4), rdata: $urandom, npc: 32'h0000_0000, stray_we: 1'b1};
    vecs[5] = '{waits: 0, rdata: 32'hFFFF_FFFF, npc: 32'h0000_3010, stray_we: 1'b0};

    // Reset and first fetch with a zero-wait memory.
    tick();
    do_reset(2);
    fetch(0, 32'h2008_0005, 1'b0);
    check("first_instr", instr, 32'h2008_0005);
    check("first_cnt",   retire_cnt, 32'd0);

    // Held decode: no commit while the memory lines toggle.
    held = 32'h2008_0005;
    for (int i = 0; i < 5; i++) begin
      imem_ack   = 1'(($urandom_range(0, 1)));
      imem_rdata = $urandom;
      tick();
      check ("hold_instr", instr,       held);
      check ("hold_pc",    pc,          RESET_PC);
      check1("hold_valid", instr_valid, 1'b1);
      check1("hold_req",   imem_req,    1'b0);
    end
    imem_ack = 1'b0;

    // Commit, then a fetch with three wait states.
    commit(32'h0000_3004);
    check("commit_cnt_one", retire_cnt, 32'd1);
    fetch(3, $urandom, 1'b0);

    // Table-driven fetch/commit transactions.
    for (int v = 0; v < 6; v++) begin
      commit(vecs[v].npc);
      fetch(vecs[v].waits, vecs[v].rdata, vecs[v].stray_we);
    end

    // Misaligned jump: parked in error until reset, everything ignored.
    commit(32'h0000_3102);
    for (int i = 0; i < 6; i++) begin
      imem_ack   = 1'(($urandom_range(0, 1)));
      imem_rdata = $urandom;
      pc_we      = 1'(($urandom_range(0, 1)));
      npc_in     = $urandom & 32'hFFFF_FFFC;
      tick();
      check ("err_pc",    pc,          32'h0000_3102);
      check1("err_flag",  addr_err,    1'b1);
      check1("err_valid", instr_valid, 1'b0);
      check1("err_req",   imem_req,    1'b0);
      check ("err_cnt",   retire_cnt,  exp_cnt);
    end
    do_reset(1);

    // Reset mid-fetch with ack and commit strobes present.
    fetch(0, 32'hA5A5_0001, 1'b0);
    commit(32'h0000_3004);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    pc_we      = 1'b1;
    npc_in     = 32'h0000_7000;
    tick();
    rst      = 1'b0;
    imem_ack = 1'b0;
    pc_we    = 1'b0;
    exp_pc   = RESET_PC;
    exp_cnt  = 32'd0;
    check ("midrst_instr", instr,       32'd0);
    check ("midrst_pc",    pc,          RESET_PC);
    check1("midrst_valid", instr_valid, 1'b0);
    check1("midrst_req",   imem_req,    1'b0);
    check ("midrst_cnt",   retire_cnt,  32'd0);
    fetch(0, 32'h1234_5678, 1'b0);

    // Counter wrap, with a stray commit strobe during the fetch.
    commit(32'h0000_3008);
    force dut.retire_cnt = 32'hFFFF_FFFF;
    pc_we  = 1'b1;
    npc_in = 32'h0000_5000;
    tick();
    release dut.retire_cnt;
    pc_we   = 1'b0;
    exp_cnt = 32'hFFFF_FFFF;
    check ("wrap_pre_pc",  pc,         32'h0000_3008);
    check ("wrap_pre_cnt", retire_cnt, 32'hFFFF_FFFF);
    check1("wrap_pre_req", imem_req,   1'b1);
    fetch(1, $urandom, 1'b1);
    commit(32'h0000_300C);
    check("wrap_cnt_zero", retire_cnt, 32'd0);
    fetch(0, $urandom, 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
